// File: rtl/ct_lsu_dcache_dirty_ram_ctrl_pkg.sv
// Shared LSU definitions for the dcache dirty array: FSM encodings,
// dcache size configuration and array depth derivation.
package ct_lsu_dcache_dirty_ram_ctrl_pkg;

  typedef enum logic [2:0] {
    SCAN_IDLE = 3'd0,
    SCAN_RD   = 3'd1,
    SCAN_CHK  = 3'd2,
    SCAN_HOLD = 3'd3,
    SCAN_DONE = 3'd4
  } scan_state_e;

  typedef enum logic {
    INIT_READY = 1'b0,
    INIT_BUSY  = 1'b1
  } init_state_e;

  typedef enum logic {
    DCACHE_32K = 1'b0,
    DCACHE_64K = 1'b1
  } dcache_cfig_e;

  localparam int unsigned DCACHE_32K_IDX_W = 8;
  localparam int unsigned DCACHE_64K_IDX_W = 9;
  localparam dcache_cfig_e CPU_CFIG_DCACHE = DCACHE_64K;

  function automatic int unsigned cfig_idx_w(input dcache_cfig_e cfg);
    return (cfg == DCACHE_32K) ? DCACHE_32K_IDX_W : DCACHE_64K_IDX_W;
  endfunction

  function automatic int unsigned depth_of(input int unsigned idx_w);
    return 32'(1) << idx_w;
  endfunction

endpackage

// File: rtl/ct_lsu_dirty_mem.sv
// Single-port dirty array with macro-style pins (active-low CEN/GWEN/WEN,
// registered Q that holds between reads); replaceable by a compiled SRAM.
module ct_lsu_dirty_mem
  import ct_lsu_dcache_dirty_ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 7
) (
  input  logic              CLK,
  input  logic              CEN,
  input  logic              GWEN,
  input  logic [DATA_W-1:0] WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/ct_lsu_dcache_dirty_ram_ctrl.sv
// Dcache dirty/status array controller: self-init after reset, host port,
// and a dirty-line scan engine that streams nonzero entries for flush/clean.
module ct_lsu_dcache_dirty_ram_ctrl
  import ct_lsu_dcache_dirty_ram_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W  = cfig_idx_w(CPU_CFIG_DCACHE),
  parameter int unsigned DATA_W = 7
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              pad_yy_icg_scan_en,
  input  logic              cp0_lsu_icg_en,
  input  logic              dirty_gateclk_en,
  input  logic              dirty_sel_b,
  input  logic              dirty_gwen_b,
  input  logic [DATA_W-1:0] dirty_wen_b,
  input  logic [IDX_W-1:0]  dirty_idx,
  input  logic [DATA_W-1:0] dirty_din,
  output logic [DATA_W-1:0] dirty_dout,
  output logic              init_busy,
  input  logic              scan_req,
  output logic              scan_busy,
  output logic              scan_vld,
  input  logic              scan_rdy,
  output logic [IDX_W-1:0]  scan_idx,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_done
);

  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  init_state_e       init_cur, init_nxt;
  logic [IDX_W-1:0]  init_cnt, init_cnt_nxt;
  scan_state_e       scan_cur, scan_nxt;
  logic [IDX_W-1:0]  scan_ptr, scan_ptr_nxt;
  logic [DATA_W-1:0] scan_data_q, scan_data_nxt;
  logic              advance;
  logic              dout_sel_q;
  logic [DATA_W-1:0] dout_hold_q;

  logic              clk_en, host_req, host_wr, host_rd, scan_rd, fwd_hit;
  logic              mem_cen, mem_gwen;
  logic [IDX_W-1:0]  mem_a;
  logic [DATA_W-1:0] mem_wen, mem_d, mem_q, wr_merged_q, wr_merged_hold;
  logic [DATA_W-1:0] chk_data, hold_data;

  // ICG enable: global_en tied high, external_en tied low.
  assign clk_en   = pad_yy_icg_scan_en | cp0_lsu_icg_en | dirty_gateclk_en | init_busy | scan_busy;
  assign host_req = !dirty_sel_b && !init_busy && clk_en;
  assign host_wr  = host_req && !dirty_gwen_b;
  assign host_rd  = host_req && dirty_gwen_b;
  assign scan_rd  = (scan_cur == SCAN_RD) && dirty_sel_b;

  // A host write to the entry under scan is merged into the scan copy on the same edge.
  assign fwd_hit        = host_wr && (dirty_idx == scan_ptr);
  assign wr_merged_q    = (mem_q & dirty_wen_b) | (dirty_din & ~dirty_wen_b);
  assign wr_merged_hold = (scan_data_q & dirty_wen_b) | (dirty_din & ~dirty_wen_b);
  assign chk_data       = fwd_hit ? wr_merged_q : mem_q;
  assign hold_data      = fwd_hit ? wr_merged_hold : scan_data_q;

  assign init_busy  = (init_cur == INIT_BUSY);
  assign scan_busy  = scan_cur inside {SCAN_RD, SCAN_CHK, SCAN_HOLD};
  assign scan_vld   = (scan_cur == SCAN_HOLD);
  assign scan_done  = (scan_cur == SCAN_DONE);
  assign scan_idx   = scan_ptr;
  assign scan_data  = scan_data_q;
  // Q is shared with the scan engine, so host data is shown live only right after a host read.
  assign dirty_dout = dout_sel_q ? mem_q : dout_hold_q;

  always_comb begin
    init_nxt     = init_cur;
    init_cnt_nxt = init_cnt;
    if (init_cur == INIT_BUSY) begin
      if (init_cnt == IDX_LAST) begin
        init_nxt = INIT_READY;
      end else begin
        init_cnt_nxt = init_cnt + IDX_W'(1);
      end
    end
  end

  always_comb begin
    scan_nxt      = scan_cur;
    scan_ptr_nxt  = scan_ptr;
    scan_data_nxt = scan_data_q;
    advance       = 1'b0;
    case (scan_cur)
      SCAN_IDLE: begin
        if (scan_req && !init_busy) begin
          scan_nxt     = SCAN_RD;
          scan_ptr_nxt = '0;
        end
      end
      SCAN_RD: begin
        if (dirty_sel_b) scan_nxt = SCAN_CHK;
      end
      SCAN_CHK: begin
        if (chk_data != '0) begin
          scan_nxt      = SCAN_HOLD;
          scan_data_nxt = chk_data;
        end else begin
          advance = 1'b1;
        end
      end
      SCAN_HOLD: begin
        scan_data_nxt = hold_data;
        advance       = scan_rdy;
      end
      SCAN_DONE: scan_nxt = SCAN_IDLE;
      default:   scan_nxt = SCAN_IDLE;
    endcase
    if (advance) begin
      if (scan_ptr == IDX_LAST) begin
        scan_nxt = SCAN_DONE;
      end else begin
        scan_nxt     = SCAN_RD;
        scan_ptr_nxt = scan_ptr + IDX_W'(1);
      end
    end
  end

  // Port mux priority: init, then host, then scan.
  always_comb begin
    mem_cen  = 1'b1;
    mem_gwen = 1'b1;
    mem_wen  = '1;
    mem_a    = init_cnt;
    mem_d    = '0;
    if (init_busy) begin
      mem_cen  = 1'b0;
      mem_gwen = 1'b0;
      mem_wen  = '0;
    end else if (host_req) begin
      mem_cen  = 1'b0;
      mem_gwen = dirty_gwen_b;
      mem_wen  = dirty_wen_b;
      mem_a    = dirty_idx;
      mem_d    = dirty_din;
    end else if (scan_rd) begin
      mem_cen = 1'b0;
      mem_a   = scan_ptr;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      init_cur    <= INIT_BUSY;
      init_cnt    <= '0;
      scan_cur    <= SCAN_IDLE;
      scan_ptr    <= '0;
      scan_data_q <= '0;
      dout_sel_q  <= 1'b0;
      dout_hold_q <= '0;
    end else begin
      init_cur    <= init_nxt;
      init_cnt    <= init_cnt_nxt;
      scan_cur    <= scan_nxt;
      scan_ptr    <= scan_ptr_nxt;
      scan_data_q <= scan_data_nxt;
      dout_sel_q  <= host_rd;
      dout_hold_q <= dirty_dout;
    end
  end

  ct_lsu_dirty_mem #(
    .ADDR_W (IDX_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .CLK  (forever_cpuclk),
    .CEN  (mem_cen),
    .GWEN (mem_gwen),
    .WEN  (mem_wen),
    .A    (mem_a),
    .D    (mem_d),
    .Q    (mem_q)
  );

endmodule

// File: tb/tb_ct_lsu_dcache_dirty_ram_ctrl.sv
// Self-checking bench for the dcache dirty array controller (IDX_W=4, DATA_W=7).
module tb_ct_lsu_dcache_dirty_ram_ctrl;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 7;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              cpurst_b = 1'b0;
  logic              pad_yy_icg_scan_en = 1'b0;
  logic              cp0_lsu_icg_en = 1'b0;
  logic              dirty_gateclk_en = 1'b1;
  logic              dirty_sel_b = 1'b1;
  logic              dirty_gwen_b = 1'b1;
  logic [DATA_W-1:0] dirty_wen_b = '1;
  logic [IDX_W-1:0]  dirty_idx = '0;
  logic [DATA_W-1:0] dirty_din = '0;
  logic [DATA_W-1:0] dirty_dout;
  logic              init_busy;
  logic              scan_req = 1'b0;
  logic              scan_busy, scan_vld, scan_done;
  logic              scan_rdy = 1'b1;
  logic [IDX_W-1:0]  scan_idx;
  logic [DATA_W-1:0] scan_data;

  ct_lsu_dcache_dirty_ram_ctrl #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (cpurst_b),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .cp0_lsu_icg_en     (cp0_lsu_icg_en),
    .dirty_gateclk_en   (dirty_gateclk_en),
    .dirty_sel_b        (dirty_sel_b),
    .dirty_gwen_b       (dirty_gwen_b),
    .dirty_wen_b        (dirty_wen_b),
    .dirty_idx          (dirty_idx),
    .dirty_din          (dirty_din),
    .dirty_dout         (dirty_dout),
    .init_busy          (init_busy),
    .scan_req           (scan_req),
    .scan_busy          (scan_busy),
    .scan_vld           (scan_vld),
    .scan_rdy           (scan_rdy),
    .scan_idx           (scan_idx),
    .scan_data          (scan_data),
    .scan_done          (scan_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: array contents, init length, host read result.
  int mmem [DEPTH];
  int exp_dout = 0;
  int init_left = 0;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (!cpurst_b) begin
      model_valid = 1'b1;
      init_left   = DEPTH;
      exp_dout    = 0;
      for (int i = 0; i < DEPTH; i++) mmem[i] = 0;
    end else if (init_left > 0) begin
      init_left--;
    end else if (!dirty_sel_b) begin
      if (!dirty_gwen_b)
        mmem[int'(dirty_idx)] = (mmem[int'(dirty_idx)] & int'(dirty_wen_b))
                              | (int'(dirty_din) & ~int'(dirty_wen_b) & 'h7F);
      else
        exp_dout = mmem[int'(dirty_idx)];
    end
  end

  // Per-cycle compare and scan-output monitor.
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int got[$];
  bit prev_stall = 1'b0;
  int prev_idx = 0;

  always @(negedge clk) begin
    cyc++;
    if (model_valid) begin
      chk("dout_model", int'(dirty_dout), exp_dout);
      chk("init_busy_model", int'(init_busy), (init_left > 0) ? 1 : 0);
      if (scan_vld) chk("scan_data_coherent", int'(scan_data), mmem[int'(scan_idx)]);
      if (prev_stall) begin
        chk("vld_held", int'(scan_vld), 1);
        chk("idx_held", int'(scan_idx), prev_idx);
      end
      if (scan_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_exclusive", int'(scan_busy | scan_vld), 0);
      end
      if (scan_vld && scan_rdy) got.push_back(int'(scan_idx) * 256 + int'(scan_data));
      prev_stall = scan_vld && !scan_rdy && cpurst_b;
      prev_idx   = int'(scan_idx);
    end
  end

  int start_cyc = 0;
  int done_before = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int idx, input int din, input int wen_b);
    dirty_sel_b  = 1'b0;
    dirty_gwen_b = 1'b0;
    dirty_idx    = IDX_W'(idx);
    dirty_din    = DATA_W'(din);
    dirty_wen_b  = DATA_W'(wen_b);
    step();
    dirty_sel_b  = 1'b1;
    dirty_gwen_b = 1'b1;
    dirty_wen_b  = '1;
  endtask

  task automatic host_rd(input string nm, input int idx, input int exp);
    dirty_sel_b  = 1'b0;
    dirty_gwen_b = 1'b1;
    dirty_idx    = IDX_W'(idx);
    step();
    dirty_sel_b  = 1'b1;
    chk(nm, int'(dirty_dout), exp);
  endtask

  task automatic scan_start();
    done_before = done_cnt;
    got.delete();
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (done_cnt > done_before) return;
    end
    chk("scan_done_timeout", 0, 1);
  endtask

  task automatic wait_vld();
    for (int i = 0; i < 500; i++) begin
      if (scan_vld) return;
      step();
    end
    chk("scan_vld_timeout", 0, 1);
  endtask

  task automatic count_init(output int n, input bit drop_host);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!init_busy) return;
      n++;
      if (drop_host && n == 8) begin
        dirty_sel_b  = 1'b1;
        dirty_gwen_b = 1'b1;
      end
    end
  endtask

  task automatic check_list(input string nm, input int exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk({nm, "_entry"}, got[i], exp[i]);
  endtask

  initial begin
    int n;
    int exp_list[$];

    // 1: reset values, init length, host write dropped during init
    repeat (3) step();
    chk("rst_dout", int'(dirty_dout), 0);
    chk("rst_init_busy", int'(init_busy), 1);
    chk("rst_scan_busy", int'(scan_busy), 0);
    chk("rst_scan_vld", int'(scan_vld), 0);
    chk("rst_scan_done", int'(scan_done), 0);
    chk("rst_scan_idx", int'(scan_idx), 0);
    chk("rst_scan_data", int'(scan_data), 0);
    dirty_sel_b  = 1'b0;
    dirty_gwen_b = 1'b0;
    dirty_idx    = 4'd3;
    dirty_din    = 7'h7F;
    dirty_wen_b  = '0;
    cpurst_b     = 1'b1;
    count_init(n, 1'b1);
    dirty_wen_b  = '1;
    chk("init_cycles", n, 16);
    for (int i = 0; i < DEPTH; i++) host_rd("init_clear", i, 0);
    host_rd("init_drop_wr3", 3, 0);

    // 2: masked writes
    host_wr(5, 'h7F, 'h00);
    host_wr(5, 'h00, 'h7E);
    host_rd("masked_wr", 5, 'h7E);
    host_wr(5, 'h00, 'h00);
    host_rd("clear5", 5, 0);

    // 3: scan with consumer always ready
    host_wr(2, 'h01, 'h00);
    host_wr(9, 'h40, 'h00);
    scan_rdy = 1'b1;
    scan_start();
    wait_done();
    chk("scan3_cycles", done_cyc - start_cyc, 35);
    chk("scan3_done_count", done_cnt - done_before, 1);
    exp_list = '{2 * 256 + 'h01, 9 * 256 + 'h40};
    check_list("scan3", exp_list);

    // 4: consumer back-pressure for 5 cycles on the first hit
    scan_rdy = 1'b0;
    scan_start();
    wait_vld();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_vld", int'(scan_vld), 1);
      chk("bp_idx", int'(scan_idx), 2);
      chk("bp_data", int'(scan_data), 'h01);
    end
    step();
    scan_rdy = 1'b1;
    wait_done();
    chk("scan4_cycles", done_cyc - start_cyc, 40);
    check_list("scan4", exp_list);

    // 5: host reads every cycle stall the scan
    dirty_sel_b  = 1'b0;
    dirty_gwen_b = 1'b1;
    dirty_idx    = 4'd0;
    done_before  = done_cnt;
    got.delete();
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      dirty_idx = IDX_W'(i % 16);
      step();
      chk("stall_busy", int'(scan_busy), 1);
      chk("stall_vld", int'(scan_vld), 0);
      chk("stall_ptr", int'(scan_idx), 0);
      chk("stall_dout", int'(dirty_dout), (i % 16 == 2) ? 'h01 : (i % 16 == 9) ? 'h40 : 0);
    end
    dirty_sel_b = 1'b1;
    wait_done();
    check_list("scan5", exp_list);

    // 6a: host write to the held entry is forwarded into scan_data
    scan_rdy = 1'b1;
    scan_start();
    for (int i = 0; i < 500; i++) begin
      step();
      if (scan_vld && scan_idx == 4'd9) break;
    end
    scan_rdy = 1'b0;
    chk("hold9_idx", int'(scan_idx), 9);
    host_wr(9, 'h00, 'h3F);
    chk("fwd_data", int'(scan_data), 'h00);
    chk("fwd_vld", int'(scan_vld), 1);
    scan_rdy = 1'b1;
    wait_done();
    exp_list = '{2 * 256 + 'h01, 9 * 256 + 'h00};
    check_list("scan6", exp_list);

    // 6b: reset during a scan aborts it and restarts init
    scan_rdy = 1'b0;
    scan_start();
    wait_vld();
    cpurst_b = 1'b0;
    step();
    step();
    chk("abort_busy", int'(scan_busy), 0);
    chk("abort_vld", int'(scan_vld), 0);
    chk("abort_init", int'(init_busy), 1);
    chk("abort_dout", int'(dirty_dout), 0);
    done_before = done_cnt;
    cpurst_b = 1'b1;
    count_init(n, 1'b0);
    chk("reinit_cycles", n, 16);
    step();
    chk("abort_no_done", done_cnt - done_before, 0);
    scan_rdy = 1'b1;
    host_rd("reinit_clear2", 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
